// File: rtl/board_reset_request.sv
// Conditions the raw board reset button into a debounced, long-hold reboot request
// for the warm-boot sequencer, plus a short-press pulse and a press indicator.
module board_reset_request #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned LOCK_CYCLES     = 1000000
) (
  input  logic Clk,
  input  logic nReset,
  input  logic Button,
  output logic Reboot,
  output logic Short_press,
  output logic Pressed
);

  localparam int unsigned MAX_DH     = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int unsigned MAX_CYCLES = (MAX_DH > LOCK_CYCLES) ? MAX_DH : LOCK_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? int'($clog2(MAX_CYCLES)) : 1;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_LOCK     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_PRESS_DB = 3'd2,
    ST_HOLD     = 3'd3,
    ST_FIRE     = 3'd4,
    ST_REL_DB   = 3'd5
  } state_t;

  logic             sync1;
  logic             btn_s;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             reboot_nxt;
  logic             short_nxt;
  logic             pressed_nxt;

  // Two-flop synchroniser for the asynchronous button level
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= Button;
      btn_s <= sync1;
    end
  end

  // State, shared counter and registered outputs
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state       <= ST_LOCK;
      cnt         <= '0;
      Reboot      <= 1'b0;
      Short_press <= 1'b0;
      Pressed     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      Reboot      <= reboot_nxt;
      Short_press <= short_nxt;
      Pressed     <= pressed_nxt;
    end
  end

  // Next-state and counter; any transition clears the counter
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    short_nxt = 1'b0;

    case (state)
      ST_LOCK: begin
        if (btn_s) begin
          cnt_nxt = '0;
        end else if (cnt == LOCK_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_IDLE: begin
        if (btn_s) begin
          state_nxt = ST_PRESS_DB;
          cnt_nxt   = '0;
        end
      end

      ST_PRESS_DB: begin
        if (!btn_s) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      // A release on the final hold cycle still counts as a short press
      ST_HOLD: begin
        if (!btn_s) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          short_nxt = 1'b1;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = ST_FIRE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_FIRE: begin
        state_nxt = ST_REL_DB;
        cnt_nxt   = '0;
      end

      ST_REL_DB: begin
        if (btn_s) begin
          cnt_nxt = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = ST_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Level/pulse outputs follow the state being entered
  always_comb begin
    reboot_nxt  = 1'b0;
    pressed_nxt = 1'b0;
    if (state_nxt == ST_FIRE) begin
      reboot_nxt = 1'b1;
    end
    if (state_nxt == ST_HOLD) begin
      pressed_nxt = 1'b1;
    end
  end

endmodule

// File: doc/board_reset_request.md
# board_reset_request

Conditions the raw board reset push-button into a clean, single-cycle reboot request for the warm-boot (ICAPE2 IPROG) sequencer. The sequencer restarts the FPGA on any cycle where its trigger is high, so a bouncing or stuck button would cause repeated or spurious reconfiguration. This block synchronises and debounces the button and requires a deliberate long hold before issuing the request. It also provides a power-up lockout and a short-press pulse for soft user reset.

## Interface
- DEBOUNCE_CYCLES, default 50000: consecutive stable samples needed to accept a press or release (≥1).
- HOLD_CYCLES, default 50000000: further cycles the debounced press must persist before a reboot is requested (≥1).
- LOCK_CYCLES, default 1000000: consecutive released cycles required after reset before presses are accepted (≥1).
- Clk  in  1  system clock; all state changes on rising edge.
- nReset  in  1  asynchronous, active-low reset.
- Button  in  1  raw push-button level, asynchronous to Clk, high = pressed.
- Reboot  out  1  registered one-cycle pulse; drives the warm-boot sequencer trigger.
- Short_press  out  1  registered one-cycle pulse on release of a debounced press shorter than the hold time.
- Pressed  out  1  registered level, high while a debounced press is being timed (LED indicator).

## Operation
- Button passes through a 2-flop synchroniser (sync1, btn_s), both cleared by nReset. All logic below uses btn_s only.
- There is one counter, wide enough for the maximum of the three parameters. Its width is computed with $clog2 from that maximum. It is cleared on every state transition.
- States and transitions:
  - LOCK (reset state):
    - btn_s=1: cnt←0.
    - Otherwise, if cnt==LOCK_CYCLES-1: go to IDLE.
    - Otherwise: cnt++.
  - IDLE:
    - btn_s=1: go to PRESS_DB.
  - PRESS_DB:
    - btn_s=0: go to IDLE, with no output.
    - btn_s=1 and cnt==DEBOUNCE_CYCLES-1: go to HOLD.
    - Otherwise: cnt++.
  - HOLD:
    - btn_s=0: go to IDLE and pulse Short_press.
    - cnt==HOLD_CYCLES-1 with btn_s=1: go to FIRE.
    - Otherwise: cnt++.
  - FIRE:
    - Reboot=1 for exactly one cycle, then go unconditionally to REL_DB.
  - REL_DB:
    - btn_s=1: cnt←0.
    - Otherwise, if cnt==DEBOUNCE_CYCLES-1: go to IDLE.
    - Otherwise: cnt++.
- When btn_s=0 and the hold time completes on the same edge in HOLD, the release wins: Short_press is issued, no Reboot.
- At most one Reboot is issued per physical press. Button held indefinitely after FIRE stays in REL_DB with no further outputs.
- A button held through power-up or reset never causes Reboot or Short_press. LOCK waits for a full release first.
- Unused state encodings: go to LOCK.

## Timing
- Reset values: Reboot=0, Short_press=0, Pressed=0, state=LOCK, cnt=0, synchroniser=0.
- Assertion of nReset clears everything immediately, including mid-HOLD or during FIRE. An in-flight Reboot pulse is truncated.
- Button-to-btn_s latency: 2 edges.
- Let e0 be the edge at which IDLE samples btn_s=1. Then, with btn_s held high:
  - HOLD is entered at e0+DEBOUNCE_CYCLES.
  - Pressed is high from edge e0+DEBOUNCE_CYCLES until HOLD is left.
  - FIRE is entered at e0+DEBOUNCE_CYCLES+HOLD_CYCLES.
  - Reboot is high for the single cycle following that edge.
- Short_press is high for the single cycle following the edge at which HOLD samples btn_s=0. Pressed falls on that same edge.
- Reboot and Short_press are never high in the same cycle.

## Test plan
All tests use DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, LOCK_CYCLES=8.
- **Power-up lockout:** Button=1 during and for 20 cycles after nReset release, then 0.
  - IDLE is reached 8 cycles after btn_s falls.
  - Reboot and Short_press stay 0 throughout.
- **Long press:** From IDLE, Button=1 for 40 cycles.
  - Pressed rises 4 edges after e0.
  - Exactly one Reboot pulse appears, in the cycle after e0+14.
  - Pressed falls with FIRE.
  - No second Reboot, both while held and after release.
- **Bounce:** Button toggles 1,0,1,0 every cycle, then stays 0.
  - The state never leaves IDLE/PRESS_DB.
  - All outputs stay 0.
- **Short press:** Button=1 for 8 cycles, then 0.
  - One Short_press pulse, two cycles after Button falls (synchroniser latency).
  - Reboot stays 0.
- **Boundary:** btn_s falls on exactly the edge where HOLD has cnt==9.
  - Short_press=1, Reboot=0.
  - Also test btn_s falling one edge later: exactly one Reboot.
- **Reset mid-operation:** Assert nReset while in HOLD.
  - All outputs are 0 immediately.
  - After release, the block restarts in LOCK and re-applies the lockout.
